// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame deframer: SOF marker, FSM states, error codes.
package uart_frame_pkg;

   localparam logic [7:0] SOF = 8'h7E;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_COMMIT
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_LEN   = 2'd1,
      ERR_SPACE = 2'd2,
      ERR_CSUM  = 2'd3
   } err_t;

endpackage

// File: rtl/uart_frame_deframer_if.sv
// Committed-payload stream between the deframer (master) and its consumer (slave).
interface uart_frame_deframer_if;

   logic       data_valid;
   logic [7:0] data_byte;
   logic       data_ready;

   modport master (output data_valid, output data_byte, input data_ready);
   modport slave  (input data_valid, input data_byte, output data_ready);

endinterface

// File: rtl/uart_frame_fifo.sv
// Commit/rollback payload FIFO: speculative writes become visible only on commit; FWFT read.
module uart_frame_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     commit,
   input  logic                     rollback,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_spec;
   logic [AW:0] wr_commit;
   logic [AW:0] rd_ptr;
   logic [7:0]  mem [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_spec   <= '0;
         wr_commit <= '0;
         rd_ptr    <= '0;
      end else begin
         if (rollback)
            wr_spec <= wr_commit;
         else if (wr_en)
            wr_spec <= wr_spec + 1'b1;
         if (commit)
            wr_commit <= wr_spec;
         if (rd_en && rd_valid)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en)
         mem[wr_spec[AW-1:0]] <= wr_data;
   end

   // Head byte forced to zero when empty so the output is defined out of reset.
   assign rd_valid = (rd_ptr != wr_commit);
   assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;
   assign level    = wr_commit - rd_ptr;

endmodule

// File: rtl/uart_frame_deframer.sv
// Extracts SOF/LEN/payload[/CSUM] frames from a UART byte stream into a commit/rollback FIFO.
// Define UART_DEFRAMER_CSUM_EN to expect and check a trailing checksum byte.
module uart_frame_deframer
   import uart_frame_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned MAX_LEN = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_rx_valid,
   input  logic [7:0]               i_rx_byte,
   uart_frame_deframer_if.master    data,
   output logic                     o_frame_done,
   output logic                     o_frame_err,
   output logic [1:0]               o_err_code,
   output logic [$clog2(DEPTH):0]   o_level
);

   logic       rx_prev;
   logic       strobe;
   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       wr_en, commit, rollback;
   logic       done_nx, err_nx;
   err_t       code_nx;
`ifdef UART_DEFRAMER_CSUM_EN
   logic [7:0] sum, sum_nx;
`endif

   assign strobe = i_rx_valid && !rx_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_prev      <= 1'b0;
         state        <= ST_HUNT;
         cnt          <= '0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         o_err_code   <= '0;
      end else begin
         rx_prev      <= i_rx_valid;
         state        <= state_nx;
         cnt          <= cnt_nx;
         o_frame_done <= done_nx;
         o_frame_err  <= err_nx;
         o_err_code   <= code_nx;
      end
   end

`ifdef UART_DEFRAMER_CSUM_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         sum <= '0;
      else
         sum <= sum_nx;
   end
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      wr_en    = 1'b0;
      commit   = 1'b0;
      rollback = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      code_nx  = ERR_NONE;
`ifdef UART_DEFRAMER_CSUM_EN
      sum_nx   = sum;
`endif
      case (state)
         ST_HUNT: begin
            if (strobe && i_rx_byte == SOF) begin
               state_nx = ST_LEN;
`ifdef UART_DEFRAMER_CSUM_EN
               sum_nx   = '0;
`endif
            end
         end
         ST_LEN: begin
            if (strobe) begin
               state_nx = ST_HUNT;
               if (i_rx_byte == 8'h00 || 32'(i_rx_byte) > MAX_LEN) begin
                  err_nx  = 1'b1;
                  code_nx = ERR_LEN;
               end else if (32'(i_rx_byte) > DEPTH - 32'(o_level)) begin
                  // Committed level only: no other frame can be in flight here.
                  err_nx  = 1'b1;
                  code_nx = ERR_SPACE;
               end else begin
                  cnt_nx   = i_rx_byte;
                  state_nx = ST_PAYLOAD;
`ifdef UART_DEFRAMER_CSUM_EN
                  sum_nx   = i_rx_byte;
`endif
               end
            end
         end
         ST_PAYLOAD: begin
            if (strobe) begin
               wr_en  = 1'b1;
               cnt_nx = cnt - 8'd1;
`ifdef UART_DEFRAMER_CSUM_EN
               sum_nx = sum + i_rx_byte;
               if (cnt == 8'd1)
                  state_nx = ST_CSUM;
`else
               if (cnt == 8'd1)
                  state_nx = ST_COMMIT;
`endif
            end
         end
`ifdef UART_DEFRAMER_CSUM_EN
         ST_CSUM: begin
            if (strobe) begin
               state_nx = ST_HUNT;
               if (8'(sum + i_rx_byte) == 8'h00) begin
                  commit  = 1'b1;
                  done_nx = 1'b1;
               end else begin
                  rollback = 1'b1;
                  err_nx   = 1'b1;
                  code_nx  = ERR_CSUM;
               end
            end
         end
`else
         ST_COMMIT: begin
            commit   = 1'b1;
            done_nx  = 1'b1;
            state_nx = ST_HUNT;
         end
`endif
         default: state_nx = ST_HUNT;
      endcase
   end

   uart_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .wr_en    (wr_en),
      .wr_data  (i_rx_byte),
      .commit   (commit),
      .rollback (rollback),
      .rd_en    (data.data_ready),
      .rd_data  (data.data_byte),
      .rd_valid (data.data_valid),
      .level    (o_level)
   );

endmodule

// File: tb/tb_uart_frame_deframer.sv
// Directed bench for uart_frame_deframer; build with or without UART_DEFRAMER_CSUM_EN.
module tb_uart_frame_deframer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       frame_done, frame_err;
   logic [1:0] err_code;
   logic [4:0] level;

   int tests = 0;
   int fails = 0;

   int done_cnt = 0, err_cnt = 0, both_cnt = 0, valid_cnt = 0;
   logic [1:0] last_code = '0;
   logic [7:0] popped[$];

   uart_frame_deframer_if dif ();

   uart_frame_deframer #(.DEPTH(16), .MAX_LEN(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_rx_valid   (rx_valid),
      .i_rx_byte    (rx_byte),
      .data         (dif),
      .o_frame_done (frame_done),
      .o_frame_err  (frame_err),
      .o_err_code   (err_code),
      .o_level      (level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (frame_done) done_cnt++;
      if (frame_err) begin
         err_cnt++;
         last_code = err_code;
      end
      if (frame_done && frame_err) both_cnt++;
      if (dif.data_valid) valid_cnt++;
      if (dif.data_valid && dif.data_ready) popped.push_back(dif.data_byte);
   end

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      repeat (hold) @(negedge clk);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$],
                             input logic [7:0] cs, input int hold);
      send_byte(8'h7E, hold);
      send_byte(len, hold);
      foreach (pl[i]) send_byte(pl[i], hold);
`ifdef UART_DEFRAMER_CSUM_EN
      send_byte(cs, hold);
`endif
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_valid = 1'b0; rx_byte = '0; dif.data_ready = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({dif.data_valid, dif.data_byte, frame_done, frame_err, err_code, level} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b b=%h d=%b e=%b c=%0d l=%0d, want all 0",
                  dif.data_valid, dif.data_byte, frame_done, frame_err, err_code, level);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (level !== 5'd0 || dif.data_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: level=%0d valid=%b, want 0/0", level, dif.data_valid);
      end
   endtask

   task automatic test_good_frame();
      int d0, p0;
      logic [7:0] pl[$];
      d0 = done_cnt; p0 = popped.size();
      pl = {8'h11, 8'h22, 8'h33};
      send_frame(8'h03, pl, 8'h97, 1);
      tests++;
      if (done_cnt - d0 !== 1) begin
         fails++;
         $display("FAIL good_done: got %0d pulses, want 1", done_cnt - d0);
      end
      tests++;
      if (popped.size() - p0 !== 3 || popped[p0] !== 8'h11 || popped[p0+1] !== 8'h22 ||
          popped[p0+2] !== 8'h33) begin
         fails++;
         $display("FAIL good_data: got %0d bytes, want 11 22 33", popped.size() - p0);
      end
      tests++;
      if (level !== 5'd0) begin
         fails++;
         $display("FAIL good_level: got %0d, want 0", level);
      end
   endtask

   task automatic test_bad_csum();
      int d0, e0, v0, p0;
      logic [7:0] pl[$];
      d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt; p0 = popped.size();
      pl = {8'h11, 8'h22, 8'h33};
      send_frame(8'h03, pl, 8'h98, 1);
`ifdef UART_DEFRAMER_CSUM_EN
      tests++;
      if (err_cnt - e0 !== 1 || last_code !== 2'd3 || done_cnt - d0 !== 0) begin
         fails++;
         $display("FAIL csum_err: errs=%0d code=%0d dones=%0d, want 1/3/0",
                  err_cnt - e0, last_code, done_cnt - d0);
      end
      tests++;
      if (valid_cnt - v0 !== 0 || popped.size() - p0 !== 0) begin
         fails++;
         $display("FAIL csum_no_data: valid cycles=%0d, want 0", valid_cnt - v0);
      end
`else
      tests++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || popped.size() - p0 !== 3) begin
         fails++;
         $display("FAIL nocsum_commit: dones=%0d errs=%0d bytes=%0d, want 1/0/3",
                  done_cnt - d0, err_cnt - e0, popped.size() - p0);
      end
`endif
      tests++;
      if (level !== 5'd0) begin
         fails++;
         $display("FAIL csum_level: got %0d, want 0", level);
      end
   endtask

   task automatic test_bad_len();
      int e0, d0, p0;
      logic [7:0] pl[$];
      e0 = err_cnt;
      send_byte(8'h7E, 1); send_byte(8'h00, 1);
      repeat (2) @(negedge clk);
      tests++;
      if (err_cnt - e0 !== 1 || last_code !== 2'd1) begin
         fails++;
         $display("FAIL len_zero: errs=%0d code=%0d, want 1/1", err_cnt - e0, last_code);
      end
      send_byte(8'h7E, 1); send_byte(8'h09, 1);
      repeat (2) @(negedge clk);
      tests++;
      if (err_cnt - e0 !== 2 || last_code !== 2'd1) begin
         fails++;
         $display("FAIL len_big: errs=%0d code=%0d, want 2/1", err_cnt - e0, last_code);
      end
      d0 = done_cnt; p0 = popped.size();
      pl = {8'h42};
      send_frame(8'h01, pl, 8'hBD, 1);
      tests++;
      if (done_cnt - d0 !== 1 || popped.size() - p0 !== 1 || popped[p0] !== 8'h42) begin
         fails++;
         $display("FAIL len_back_to_hunt: dones=%0d bytes=%0d, want 1/1 (42)",
                  done_cnt - d0, popped.size() - p0);
      end
   endtask

   task automatic test_no_space();
      int d0, e0, p0;
      logic [7:0] pa[$], pb[$], pc[$], exp[$];
      pa = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      pb = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
      pc = {8'h5A};
      dif.data_ready = 1'b0;
      d0 = done_cnt; e0 = err_cnt;
      send_frame(8'h08, pa, 8'hD4, 1);
      send_frame(8'h08, pb, 8'h54, 1);
      tests++;
      if (done_cnt - d0 !== 2 || level !== 5'd16) begin
         fails++;
         $display("FAIL space_fill: dones=%0d level=%0d, want 2/16", done_cnt - d0, level);
      end
      send_byte(8'h7E, 1); send_byte(8'h08, 1);
      repeat (2) @(negedge clk);
      tests++;
      if (err_cnt - e0 !== 1 || last_code !== 2'd2 || level !== 5'd16) begin
         fails++;
         $display("FAIL space_err: errs=%0d code=%0d level=%0d, want 1/2/16",
                  err_cnt - e0, last_code, level);
      end
      p0 = popped.size();
      @(negedge clk); dif.data_ready = 1'b1;
      @(negedge clk); dif.data_ready = 1'b0;
      tests++;
      if (popped.size() - p0 !== 1 || popped[p0] !== 8'h01 || level !== 5'd15) begin
         fails++;
         $display("FAIL space_pop: bytes=%0d level=%0d, want 1 (01)/15", popped.size() - p0, level);
      end
      send_frame(8'h01, pc, 8'hA5, 1);
      tests++;
      if (done_cnt - d0 !== 3 || level !== 5'd16) begin
         fails++;
         $display("FAIL space_refill: dones=%0d level=%0d, want 3/16", done_cnt - d0, level);
      end
      exp = {8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h5A};
      p0 = popped.size();
      dif.data_ready = 1'b1;
      repeat (20) @(negedge clk);
      tests++;
      if (popped.size() - p0 !== 16 || level !== 5'd0) begin
         fails++;
         $display("FAIL space_drain_count: bytes=%0d level=%0d, want 16/0", popped.size() - p0, level);
      end else begin
         foreach (exp[i]) begin
            tests++;
            if (popped[p0+i] !== exp[i]) begin
               fails++;
               $display("FAIL space_drain_byte%0d: got %h, want %h", i, popped[p0+i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_long_valid();
      int d0, e0, p0;
      logic [7:0] pl[$];
      d0 = done_cnt; e0 = err_cnt; p0 = popped.size();
      send_byte(8'h55, 20);
      send_byte(8'hAA, 20);
      pl = {8'hA1, 8'hB2};
      send_frame(8'h02, pl, 8'hAB, 20);
      tests++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
         fails++;
         $display("FAIL long_valid_done: dones=%0d errs=%0d, want 1/0", done_cnt - d0, err_cnt - e0);
      end
      tests++;
      if (popped.size() - p0 !== 2 || popped[p0] !== 8'hA1 || popped[p0+1] !== 8'hB2) begin
         fails++;
         $display("FAIL long_valid_data: bytes=%0d, want 2 (A1 B2)", popped.size() - p0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0, p0;
      logic [7:0] pl[$];
      send_byte(8'h7E, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if ({dif.data_valid, dif.data_byte, frame_done, frame_err, err_code, level} !== '0) begin
         fails++;
         $display("FAIL midrst_outputs: v=%b b=%h d=%b e=%b c=%0d l=%0d, want all 0",
                  dif.data_valid, dif.data_byte, frame_done, frame_err, err_code, level);
      end
      repeat (2) @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      d0 = done_cnt; p0 = popped.size();
      pl = {8'h11, 8'h22, 8'h33};
      send_frame(8'h03, pl, 8'h97, 1);
      tests++;
      if (done_cnt - d0 !== 1 || popped.size() - p0 !== 3 || popped[p0] !== 8'h11 ||
          popped[p0+2] !== 8'h33 || level !== 5'd0) begin
         fails++;
         $display("FAIL midrst_recover: dones=%0d bytes=%0d level=%0d, want 1/3/0",
                  done_cnt - d0, popped.size() - p0, level);
      end
   endtask

   task automatic test_pulse_exclusive();
      tests++;
      if (both_cnt !== 0) begin
         fails++;
         $display("FAIL done_err_overlap: got %0d cycles, want 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_bad_len();
      test_no_space();
      test_long_valid();
      test_reset_mid_frame();
      test_pulse_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
